elbeth_mem_arbiter: RTL and testbench
=====================================

Name: elbeth_mem_arbiter

Overview:
- Parametrised N-channel memory arbiter that shares one external memory port between several requesters.
- It is the successor to the fixed two-port instruction/data bridge. Requesters are the IF fetch path, the EXS load/store path, and future masters such as debug or DMA.
- Each accepted request is latched. The arbiter drives exactly one memory transaction at a time, then returns ready or error to the granted channel only.
- Adds round-robin or fixed-priority arbitration and a memory timeout. The previous bridge had neither.

Parameters:
- N_PORTS, 2: number of requester channels (1..8).
- ADDR_WIDTH, 14: memory word address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, port 0 highest.
- TIMEOUT, 255: cycles to wait for mem_ready or mem_error before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_en  in  N_PORTS  per-channel request. Held high with operands stable until that channel's ready or error pulse.
- req_addr  in  N_PORTS*ADDR_WIDTH  packed addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_rw  in  N_PORTS*(DATA_WIDTH/8)  packed byte-write masks; all zeros means read.
- req_wdata  in  N_PORTS*DATA_WIDTH  packed write data.
- req_ready  out  N_PORTS  one-cycle completion pulse on the granted channel.
- req_error  out  N_PORTS  one-cycle error pulse on the granted channel (memory error or timeout).
- req_rdata  out  DATA_WIDTH  read data; valid in the cycle req_ready pulses.
- mem_en  out  1  memory transaction active.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_rw  out  DATA_WIDTH/8  latched byte mask.
- mem_wdata  out  DATA_WIDTH  latched write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  memory completion.
- mem_error  in  1  memory error.
- grant_id  out  $clog2(N_PORTS) (minimum 1)  index of the current or last grant.
- timeout_flag  out  1  one-cycle pulse when a timeout aborts a transaction.

Behaviour:
- Reset (rst=0, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - All outputs 0: mem_en, mem_addr, mem_rw, mem_wdata, req_ready, req_error, req_rdata, grant_id, timeout_flag.
  - Round-robin pointer = N_PORTS-1, so port 0 wins the first round-robin arbitration.
  - Timeout counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req_en bit is set, select a winner, latch its addr/rw/wdata into the mem_* registers, set grant_id, and go to BUSY. mem_en rises the cycle after the request is sampled.
  - If no req_en bit is set, stay in IDLE with mem_en=0.
- Arbitration:
  - ARB_MODE=0: search from (pointer+1) mod N_PORTS upward with wrap-around. The pointer is updated to the winner on grant.
  - ARB_MODE=1: the lowest set index wins; the pointer is unused.
- BUSY:
  - mem_en=1; mem_* outputs are held constant. The counter increments every cycle.
  - mem_ready=1 (with or without mem_error):
    - mem_error=0: pulse req_ready[grant_id] next cycle, register req_rdata <= mem_rdata.
    - mem_error=1: pulse req_error[grant_id] instead; req_rdata is unchanged.
    - In both cases, go to DONE.
  - mem_error=1 with mem_ready=0: pulse req_error[grant_id] and go to DONE.
  - TIMEOUT != 0 and counter reaches TIMEOUT-1 with no response: pulse req_error[grant_id] and timeout_flag, go to DONE.
  - mem_en drops to 0 in the same cycle the response pulse appears.
- DONE:
  - Exactly one cycle with no new grant, so the served channel can drop req_en.
  - Counter cleared. Go to IDLE.
- Sustained single requester: back-to-back requests complete at most once every 3 cycles plus memory latency.
- Latency: request sampled at edge t → mem_en=1 from t+1 → zero-wait memory (mem_ready high in the first BUSY cycle) gives req_ready at t+2.
- Requester drops req_en while in BUSY: the transaction still completes and the pulse is still issued (memory cannot abort). Response is ignored by the requester.
- Late memory responses: a mem_ready or mem_error arriving in IDLE or DONE (e.g. after a timeout) is ignored.
- Non-granted channels never see pulses. At most one bit of req_ready|req_error is set per cycle.
- N_PORTS=1: arbitration degenerates to a pass-through; grant_id is always 0.

Test Plan:
- Single read, zero-wait: port0 requests addr 0x0010, rw=0; memory returns 0xDEADBEEF with mem_ready on the first BUSY cycle → mem_en high one cycle, mem_addr=0x0010, req_ready[0] pulse at t+2, req_rdata=0xDEADBEEF, req_ready[1]=0.
- Round-robin fairness: N_PORTS=2, both ports request continuously, 1-cycle memory → grants alternate 0,1,0,1; each port gets 2 of 4 completions; grant_id follows 0,1,0,1.
- Fixed priority: ARB_MODE=1, both request continuously → port0 gets every grant; port1 is served only after port0 deasserts.
- Timeout: TIMEOUT=4, mem_ready held 0 → after 4 BUSY cycles req_error[g] and timeout_flag pulse together, mem_en=0; a mem_ready arriving 2 cycles later produces no pulse.
- Write with error: port1 writes 0x12345678, rw=4'b0011, addr 0x3FFF; memory asserts mem_error → mem_rw=0011, mem_wdata=0x12345678, req_error[1] pulse, req_ready all 0, req_rdata unchanged.
- Reset mid-BUSY: assert rst=0 during the 2nd BUSY cycle → mem_en and grant_id go to 0 immediately; after release, a port0 request is served normally.

Source files
------------

// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory port between N_PORTS requesters, one latched transaction at a time
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_req_en/addr/rw/wdata          packed per-channel requests (rw all zeros = read)
//   o_req_ready/o_req_error         one-cycle completion/error pulse on the granted channel
//   o_req_rdata                     read data, valid with o_req_ready
//   o_mem_en/addr/rw/wdata          latched transaction toward memory
//   i_mem_rdata/ready/error         memory response
//   o_grant_id, o_timeout_flag      current/last grant, timeout abort pulse
module elbeth_mem_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic [N_PORTS-1:0]                        i_req_en,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]             i_req_addr,
    input  logic [N_PORTS*(DATA_WIDTH/8)-1:0]         i_req_rw,
    input  logic [N_PORTS*DATA_WIDTH-1:0]             i_req_wdata,
    output logic [N_PORTS-1:0]                        o_req_ready,
    output logic [N_PORTS-1:0]                        o_req_error,
    output logic [DATA_WIDTH-1:0]                     o_req_rdata,
    output logic                                      o_mem_en,
    output logic [ADDR_WIDTH-1:0]                     o_mem_addr,
    output logic [DATA_WIDTH/8-1:0]                   o_mem_rw,
    output logic [DATA_WIDTH-1:0]                     o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]                     i_mem_rdata,
    input  logic                                      i_mem_ready,
    input  logic                                      i_mem_error,
    output logic [$clog2(N_PORTS > 1 ? N_PORTS : 2)-1:0] o_grant_id,
    output logic                                      o_timeout_flag
);
    localparam int GW = $clog2(N_PORTS > 1 ? N_PORTS : 2);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT > 2 ? TIMEOUT : 2);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BW-1:0]         r_mem_rw;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [N_PORTS-1:0]    r_ready;
    logic [N_PORTS-1:0]    r_error;
    logic                  r_tflag;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;

    logic [GW-1:0]         w_base;
    logic [GW-1:0]         w_idx;
    logic [GW-1:0]         w_win;
    logic                  w_hit;
    logic                  w_timeout;
    logic [N_PORTS-1:0]    w_onehot;

    // Fixed priority is round-robin with the pointer pinned to the last port,
    // so the search always starts at port 0.
    assign w_base    = (ARB_MODE == 1) ? GW'(N_PORTS - 1) : r_ptr;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_onehot  = N_PORTS'(1) << r_grant;

    always_comb begin
        w_win = '0;
        w_idx = '0;
        w_hit = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_idx = GW'((int'(w_base) + k) % N_PORTS);
            if (!w_hit && i_req_en[w_idx]) begin
                w_win = w_idx;
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rw    <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_ready     <= '0;
            r_error     <= '0;
            r_tflag     <= 1'b0;
            r_grant     <= '0;
            r_ptr       <= GW'(N_PORTS - 1);
            r_cnt       <= '0;
        end else begin
            r_ready <= '0;
            r_error <= '0;
            r_tflag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|i_req_en) begin
                        r_state     <= BUSY;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= i_req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_rw    <= i_req_rw[w_win*BW +: BW];
                        r_mem_wdata <= i_req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                        r_grant     <= w_win;
                        r_ptr       <= w_win;
                        r_cnt       <= '0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_ready || i_mem_error || w_timeout) begin
                        r_state  <= DONE;
                        r_mem_en <= 1'b0;
                        if (i_mem_ready && !i_mem_error) begin
                            r_ready <= w_onehot;
                            r_rdata <= i_mem_rdata;
                        end else begin
                            r_error <= w_onehot;
                            // a real response in the timeout cycle wins over the timeout
                            r_tflag <= !i_mem_ready && !i_mem_error;
                        end
                    end
                end
                DONE: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready    = r_ready;
    assign o_req_error    = r_error;
    assign o_req_rdata    = r_rdata;
    assign o_mem_en       = r_mem_en;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_rw       = r_mem_rw;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_grant_id     = r_grant;
    assign o_timeout_flag = r_tflag;
endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// tb_elbeth_mem_arbiter: random requests and memory responses against a transaction-level model, round-robin and fixed-priority instances
module tb_elbeth_mem_arbiter;
    localparam int NP = 3;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_en [2];
    logic [NP*AW-1:0] req_addr [2];
    logic [NP*BW-1:0] req_rw [2];
    logic [NP*DW-1:0] req_wdata [2];
    logic [DW-1:0]    mem_rdata;
    logic             mem_ready;
    logic             mem_error;

    logic [NP-1:0] o_rdy [2];
    logic [NP-1:0] o_err [2];
    logic [DW-1:0] o_rd [2];
    logic          o_men [2];
    logic [AW-1:0] o_addr [2];
    logic [BW-1:0] o_rw [2];
    logic [DW-1:0] o_wd [2];
    logic [1:0]    o_gid [2];
    logic          o_tf [2];

    elbeth_mem_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(4)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_en(req_en[0]), .i_req_addr(req_addr[0]), .i_req_rw(req_rw[0]), .i_req_wdata(req_wdata[0]),
        .o_req_ready(o_rdy[0]), .o_req_error(o_err[0]), .o_req_rdata(o_rd[0]),
        .o_mem_en(o_men[0]), .o_mem_addr(o_addr[0]), .o_mem_rw(o_rw[0]), .o_mem_wdata(o_wd[0]),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .i_mem_error(mem_error),
        .o_grant_id(o_gid[0]), .o_timeout_flag(o_tf[0])
    );

    elbeth_mem_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_en(req_en[1]), .i_req_addr(req_addr[1]), .i_req_rw(req_rw[1]), .i_req_wdata(req_wdata[1]),
        .o_req_ready(o_rdy[1]), .o_req_error(o_err[1]), .o_req_rdata(o_rd[1]),
        .o_mem_en(o_men[1]), .o_mem_addr(o_addr[1]), .o_mem_rw(o_rw[1]), .o_mem_wdata(o_wd[1]),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .i_mem_error(mem_error),
        .o_grant_id(o_gid[1]), .o_timeout_flag(o_tf[1])
    );

    int waited [2];
    bit cool [2];
    int ptr [2];
    logic          e_men [2];
    logic [AW-1:0] e_addr [2];
    logic [BW-1:0] e_rw [2];
    logic [DW-1:0] e_wd [2];
    logic [DW-1:0] e_rd [2];
    int            e_gid [2];
    logic [NP-1:0] e_rdy [2];
    logic [NP-1:0] e_err [2];
    logic          e_tf [2];
    bit pend [2][NP];
    int n_cmp = 0;
    int n_bad = 0;
    bit rst_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            waited[d] = -1;
            cool[d] = 0;
            ptr[d] = NP - 1;
            e_men[d] = 0;
            e_addr[d] = '0;
            e_rw[d] = '0;
            e_wd[d] = '0;
            e_rd[d] = '0;
            e_gid[d] = 0;
            e_rdy[d] = '0;
            e_err[d] = '0;
            e_tf[d] = 0;
        end
    endtask

    function automatic int pick(input int d);
        if (d == 1) begin
            for (int c = 0; c < NP; c++)
                if (req_en[d][c]) return c;
        end else begin
            for (int off = 1; off <= NP; off++)
                if (req_en[d][(ptr[d] + off) % NP]) return (ptr[d] + off) % NP;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        int to;
        int w;
        to = (d == 0) ? 4 : 0;
        e_rdy[d] = '0;
        e_err[d] = '0;
        e_tf[d] = 0;
        if (cool[d]) begin
            cool[d] = 0;
        end else if (waited[d] >= 0) begin
            if (mem_ready || mem_error || (to != 0 && waited[d] == to - 1)) begin
                e_men[d] = 0;
                waited[d] = -1;
                cool[d] = 1;
                if (mem_ready && !mem_error) begin
                    e_rdy[d][e_gid[d]] = 1'b1;
                    e_rd[d] = mem_rdata;
                end else begin
                    e_err[d][e_gid[d]] = 1'b1;
                    e_tf[d] = !mem_ready && !mem_error;
                end
            end else begin
                waited[d]++;
            end
        end else begin
            w = pick(d);
            if (w >= 0) begin
                waited[d] = 0;
                e_men[d] = 1;
                e_gid[d] = w;
                ptr[d] = w;
                e_addr[d] = req_addr[d][w*AW +: AW];
                e_rw[d] = req_rw[d][w*BW +: BW];
                e_wd[d] = req_wdata[d][w*DW +: DW];
            end
        end
    endtask

    task automatic drive_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NP; c++) begin
                if (e_rdy[d][c] || e_err[d][c]) pend[d][c] = 0;
                if (!pend[d][c]) begin
                    req_en[d][c] = 1'b0;
                    if ($urandom_range(0, 99) < 40) begin
                        pend[d][c] = 1;
                        req_en[d][c] = 1'b1;
                        req_addr[d][c*AW +: AW] = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
                        req_rw[d][c*BW +: BW] = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
                        req_wdata[d][c*DW +: DW] = $urandom;
                    end
                end
            end
        end
        mem_ready = $urandom_range(0, 99) < 30;
        mem_error = $urandom_range(0, 99) < 10;
        mem_rdata = $urandom;
        for (int d = 0; d < 2; d++) model_step(d);
    endtask

    task automatic compare_all();
        string p;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "rr" : "fp";
            check({p, ".mem_en"}, 64'(o_men[d]), 64'(e_men[d]));
            check({p, ".mem_addr"}, 64'(o_addr[d]), 64'(e_addr[d]));
            check({p, ".mem_rw"}, 64'(o_rw[d]), 64'(e_rw[d]));
            check({p, ".mem_wdata"}, 64'(o_wd[d]), 64'(e_wd[d]));
            check({p, ".grant_id"}, 64'(o_gid[d]), 64'(e_gid[d]));
            check({p, ".req_ready"}, 64'(o_rdy[d]), 64'(e_rdy[d]));
            check({p, ".req_error"}, 64'(o_err[d]), 64'(e_err[d]));
            check({p, ".req_rdata"}, 64'(o_rd[d]), 64'(e_rd[d]));
            check({p, ".timeout_flag"}, 64'(o_tf[d]), 64'(e_tf[d]));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_en[d] = '0;
            req_addr[d] = '0;
            req_rw[d] = '0;
            req_wdata[d] = '0;
            for (int c = 0; c < NP; c++) pend[d][c] = 0;
        end
        mem_ready = 0;
        mem_error = 0;
        mem_rdata = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive_step();
            @(negedge clk);
            compare_all();
            if (!rst_done && cyc >= 200 && waited[0] == 1) begin
                rst_done = 1;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                compare_all();
                rst_n = 1'b1;
            end
        end
        check("mid_busy_reset_reached", 64'(rst_done), 64'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
